// File: rtl/fp_addsub_seq.sv
// Bit-serial floating-point add/subtract: RNE rounding, flush-to-zero inputs, exact-zero detection.
// Latency 2W load + at most 2*MAN_W+12 compute + W unload; no backpressure, start is ignored while busy.
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic sub,
    input  logic sdi,
    output logic sdo,
    output logic sdo_valid,
    output logic busy,
    output logic done,
    output logic over,
    output logic under,
    output logic zero
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SW    = MAN_W + 5;
    localparam int CW    = $clog2(W + 1);
    localparam int MAXSH = MAN_W + 3;

    localparam logic [EXP_W-1:0] EMAX    = '1;
    localparam logic [EXP_W-1:0] EMAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] EONE    = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST    = CW'(W - 1);
    localparam logic [CW-1:0]    CONE    = CW'(1);

    typedef enum logic [3:0] {
        IDLE, LOAD_A, LOAD_B, UNPACK, ALIGN, ADD, NORM, ROUND, PACK, SHOUT
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [W-1:0]       a_sr, b_sr, out_sr;
    logic [SW-1:0]      ma, mb;
    logic [EXP_W-1:0]   exp_r;
    logic [MAN_W-1:0]   frac_r;
    logic               sign_r, eff_sub, sub_r;

    logic               sa, sb, b_gt, s_big;
    logic [EXP_W-1:0]   ea, eb, e_big, e_small, ediff;
    logic [MAN_W-1:0]   fa, fb;
    logic [SW-1:0]      sig_a, sig_b, sig_big, sig_small, sum;
    logic [CW-1:0]      sh;
    logic               rnd_inc;
    logic [MAN_W+1:0]   rnd;

    always_comb begin
        sa    = a_sr[W-1];
        ea    = a_sr[W-2 -: EXP_W];
        fa    = (ea == '0) ? '0 : a_sr[MAN_W-1:0];
        sb    = b_sr[W-1] ^ sub_r;
        eb    = b_sr[W-2 -: EXP_W];
        fb    = (eb == '0) ? '0 : b_sr[MAN_W-1:0];
        sig_a = {1'b0, ea != '0, fa, 3'b000};
        sig_b = {1'b0, eb != '0, fb, 3'b000};
        // Larger magnitude always goes to the A side so the aligned difference never goes negative.
        b_gt  = {eb, fb} > {ea, fa};
        if (b_gt) begin
            e_big = eb; e_small = ea; sig_big = sig_b; sig_small = sig_a; s_big = sb;
        end else begin
            e_big = ea; e_small = eb; sig_big = sig_a; sig_small = sig_b; s_big = sa;
        end
        ediff = e_big - e_small;
        if (int'(ediff) > MAXSH)
            sh = CW'(MAXSH);
        else
            sh = CW'(ediff);
        sum     = eff_sub ? (ma - mb) : (ma + mb);
        rnd_inc = ma[2] & (ma[1] | ma[0] | ma[3]);
        rnd     = ma[SW-1:3] + {{(MAN_W+1){1'b0}}, rnd_inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            out_sr    <= '0;
            ma        <= '0;
            mb        <= '0;
            exp_r     <= '0;
            frac_r    <= '0;
            sign_r    <= 1'b0;
            eff_sub   <= 1'b0;
            sub_r     <= 1'b0;
            sdo       <= 1'b0;
            sdo_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            over      <= 1'b0;
            under     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        over  <= 1'b0;
                        under <= 1'b0;
                        zero  <= 1'b0;
                        sub_r <= sub;
                        cnt   <= '0;
                        state <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    a_sr <= {a_sr[W-2:0], sdi};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= LOAD_B;
                    end else begin
                        cnt <= cnt + CONE;
                    end
                end
                LOAD_B: begin
                    b_sr <= {b_sr[W-2:0], sdi};
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= UNPACK;
                    end else begin
                        cnt <= cnt + CONE;
                    end
                end
                UNPACK: begin
                    if (ea == EMAX || eb == EMAX) begin
                        sign_r <= (ea == EMAX) ? sa : sb;
                        exp_r  <= EMAX;
                        frac_r <= '0;
                        over   <= 1'b1;
                        state  <= PACK;
                    end else begin
                        sign_r  <= s_big;
                        eff_sub <= sa ^ sb;
                        exp_r   <= e_big;
                        ma      <= sig_big;
                        mb      <= sig_small;
                        cnt     <= sh;
                        state   <= (sh == '0) ? ADD : ALIGN;
                    end
                end
                ALIGN: begin
                    mb  <= {1'b0, mb[SW-1:2], mb[1] | mb[0]};
                    cnt <= cnt - CONE;
                    if (cnt == CONE)
                        state <= ADD;
                end
                ADD: begin
                    if (sum == '0) begin
                        sign_r <= 1'b0;
                        exp_r  <= '0;
                        frac_r <= '0;
                        zero   <= 1'b1;
                        state  <= PACK;
                    end else begin
                        ma    <= sum;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (ma[SW-1]) begin
                        ma <= {1'b0, ma[SW-1:2], ma[1] | ma[0]};
                        if (exp_r == EMAX_M1) begin
                            exp_r  <= EMAX;
                            frac_r <= '0;
                            over   <= 1'b1;
                            state  <= PACK;
                        end else begin
                            exp_r <= exp_r + EONE;
                            state <= ROUND;
                        end
                    end else if (!ma[SW-2]) begin
                        if (exp_r == EONE) begin
                            exp_r  <= '0;
                            frac_r <= '0;
                            under  <= 1'b1;
                            state  <= PACK;
                        end else begin
                            ma    <= {ma[SW-2:0], 1'b0};
                            exp_r <= exp_r - EONE;
                        end
                    end else begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    // A rounding carry leaves an all-zero fraction one binade up.
                    if (rnd[MAN_W+1]) begin
                        frac_r <= rnd[MAN_W:1];
                        if (exp_r == EMAX_M1) begin
                            exp_r  <= EMAX;
                            frac_r <= '0;
                            over   <= 1'b1;
                        end else begin
                            exp_r <= exp_r + EONE;
                        end
                    end else begin
                        frac_r <= rnd[MAN_W-1:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    out_sr    <= {sign_r, exp_r, frac_r};
                    sdo       <= sign_r;
                    sdo_valid <= 1'b1;
                    cnt       <= '0;
                    state     <= SHOUT;
                end
                SHOUT: begin
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == LAST) begin
                        sdo       <= 1'b0;
                        sdo_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        sdo    <= out_sr[W-2];
                        out_sr <= {out_sr[W-2:0], 1'b0};
                        cnt    <= cnt + CONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: single-precision and half-precision builds against an exact-arithmetic model.
module tb_fp_addsub_seq;
    localparam int BW = 320;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] start, sub, sdi;
    logic [1:0] sdo, sdo_valid, busy, done, over, under, zero;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  flags;
        logic [31:0] word;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    fp_addsub_seq dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .sub(sub[0]), .sdi(sdi[0]),
        .sdo(sdo[0]), .sdo_valid(sdo_valid[0]), .busy(busy[0]), .done(done[0]),
        .over(over[0]), .under(under[0]), .zero(zero[0])
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .sub(sub[1]), .sdi(sdi[1]),
        .sdo(sdo[1]), .sdo_valid(sdo_valid[1]), .busy(busy[1]), .done(done[1]),
        .over(over[1]), .under(under[1]), .zero(zero[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic logic [31:0] pack(input int w, input int mw, input logic sg, input int e,
                                         input logic [31:0] f);
        return (32'(sg) << (w - 1)) | (32'(e) << mw) | f;
    endfunction

    // Exact sum on a wide integer grid, then round-to-nearest-even; returns {over,under,zero,word}.
    function automatic logic [34:0] ref_model(input int ew, input int mw, input logic [31:0] a,
                                              input logic [31:0] b, input logic s);
        int w, emax, ea, eb, p, e, sh;
        logic sa, sb, sr;
        logic [BW-1:0] one, fmask, ia, ib, mag, keep, rem, half;
        w     = 1 + ew + mw;
        emax  = (1 << ew) - 1;
        one   = 1;
        fmask = (one << mw) - one;
        sa    = a[w-1];
        sb    = b[w-1] ^ s;
        ea    = int'(a >> mw) & emax;
        eb    = int'(b >> mw) & emax;
        if (ea == emax) return {3'b100, pack(w, mw, sa, emax, 32'd0)};
        if (eb == emax) return {3'b100, pack(w, mw, sb, emax, 32'd0)};
        ia = (ea == 0) ? '0 : ((one << mw) | (BW'(a) & fmask)) << (ea - 1);
        ib = (eb == 0) ? '0 : ((one << mw) | (BW'(b) & fmask)) << (eb - 1);
        if (sa == sb) begin
            mag = ia + ib; sr = sa;
        end else if (ia >= ib) begin
            mag = ia - ib; sr = sa;
        end else begin
            mag = ib - ia; sr = sb;
        end
        if (mag == '0) return {3'b001, 32'd0};
        p = -1;
        for (int i = 0; i < BW; i++) if (mag[i]) p = i;
        e = p - mw + 1;
        if (e < 1) return {3'b010, pack(w, mw, sr, 0, 32'd0)};
        sh   = p - mw;
        keep = mag >> sh;
        rem  = mag - (keep << sh);
        half = (sh > 0) ? (one << (sh - 1)) : '0;
        if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + one;
        if (keep == (one << (mw + 1))) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= emax) return {3'b100, pack(w, mw, sr, emax, 32'd0)};
        return {3'b000, pack(w, mw, sr, e, 32'(keep & fmask))};
    endfunction

    // Monitor: collects each serial result and checks it against the head of the queue.
    int          nb[2]  = '{0, 0};
    logic [31:0] acc[2] = '{32'd0, 32'd0};
    logic [2:0]  flg[2] = '{3'd0, 3'd0};
    logic        ad[2]  = '{1'b0, 1'b0};
    exp_t        e_mon;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sdo_valid[k]) begin
                if (nb[k] == 0) begin
                    acc[k] = 32'd0;
                    flg[k] = {over[k], under[k], zero[k]};
                end
                acc[k] = {acc[k][30:0], sdo[k]};
                nb[k]++;
            end else if (nb[k] != 0) begin
                chk("done_pulse", 64'(done[k]), 64'd1);
                chk("sdo_valid_len", 64'(nb[k]), (k == 0) ? 64'd32 : 64'd16);
                chk("sdo_idle_zero", 64'(sdo[k]), 64'd0);
                if (k == 0 && q0.size() > 0) begin
                    e_mon = q0.pop_front();
                    chk("result0", 64'(acc[k]), 64'(e_mon.word));
                    chk("flags0", 64'(flg[k]), 64'(e_mon.flags));
                    chk("flags0_held", 64'({over[k], under[k], zero[k]}), 64'(e_mon.flags));
                end else if (k == 1 && q1.size() > 0) begin
                    e_mon = q1.pop_front();
                    chk("result1", 64'(acc[k]), 64'(e_mon.word));
                    chk("flags1", 64'(flg[k]), 64'(e_mon.flags));
                    chk("flags1_held", 64'({over[k], under[k], zero[k]}), 64'(e_mon.flags));
                end else begin
                    fail_now("unexpected_result");
                end
                nb[k] = 0;
                ad[k] = 1'b1;
            end else if (ad[k]) begin
                chk("busy_done_after_done", 64'({busy[k], done[k]}), 64'd0);
                ad[k] = 1'b0;
            end else if (done[k]) begin
                fail_now("stray_done");
            end
        end
    end

    // mode 0: plain op; 1: start pulses in LOAD_B, SHOUT and the done cycle; 2: reset mid-LOAD_B.
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int mode);
        int w, n;
        w = (k == 0) ? 32 : 16;
        n = 0;
        while ((busy[k] || done[k]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("wait_idle");
        start[k] = 1'b1;
        sub[k]   = s;
        if (mode != 2) begin
            if (k == 0) q0.push_back(exp_t'(ref_model(8, 23, a, b, s)));
            else        q1.push_back(exp_t'(ref_model(5, 10, a, b, s)));
        end
        @(negedge clk);
        start[k] = 1'b0;
        sub[k]   = ~s;
        chk("busy_after_start", 64'(busy[k]), 64'd1);
        for (int i = 0; i < 2 * w; i++) begin
            sdi[k] = (i < w) ? a[w-1-i] : b[2*w-1-i];
            if (mode == 1) start[k] = (i == w + 3);
            if (mode == 2 && i == w + 5) begin
                reset = 1'b1;
                @(negedge clk);
                reset  = 1'b0;
                sdi[k] = 1'b0;
                chk("reset_mid_load", 64'({sdo[k], sdo_valid[k], busy[k], done[k], over[k], under[k], zero[k]}), 64'd0);
                return;
            end
            @(negedge clk);
        end
        sdi[k]   = 1'b0;
        start[k] = 1'b0;
        if (mode == 1) begin
            n = 0;
            while (!sdo_valid[k] && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) fail_now("wait_sdo_valid");
            repeat (3) @(negedge clk);
            start[k] = 1'b1;
            @(negedge clk);
            start[k] = 1'b0;
            n = 0;
            while (!done[k] && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) fail_now("wait_done");
            start[k] = 1'b1;
            @(negedge clk);
            start[k] = 1'b0;
        end
    endtask

    task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
        int ea, eb;
        ea = int'($urandom_range(0, 255));
        a  = {1'($urandom), 8'(ea), 23'($urandom)};
        if ($urandom_range(0, 2) == 0) begin
            b = $urandom;
        end else begin
            eb = ea + int'($urandom_range(0, 6)) - 3;
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            b = {1'($urandom), 8'(eb), 23'($urandom)};
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        int n;
        start = '0;
        sub   = '0;
        sdi   = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", 64'({sdo, sdo_valid, busy, done, over, under, zero}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(0, 32'h3F800000, 32'h40000000, 1'b0, 0);
        run_op(0, 32'h3FC00000, 32'h3FC00000, 1'b1, 0);
        run_op(0, 32'h40000000, 32'hC0400000, 1'b0, 0);
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 0);
        run_op(0, 32'h7F800000, 32'h3F800000, 1'b0, 0);
        run_op(0, 32'h3F800000, 32'h33800000, 1'b0, 0);
        run_op(0, 32'h3F800000, 32'h33800001, 1'b0, 0);
        run_op(0, 32'h3F800000, 32'h00800000, 1'b0, 0);
        run_op(0, 32'h00800001, 32'h00800000, 1'b1, 0);
        run_op(0, 32'h00000005, 32'h3F800000, 1'b0, 0);
        run_op(0, 32'h3F800000, 32'h40000000, 1'b0, 1);
        run_op(0, 32'h3F800000, 32'h40000000, 1'b0, 2);
        run_op(0, 32'h40400000, 32'h3F800000, 1'b1, 0);
        for (int i = 0; i < 30; i++) begin
            rand_pair(ra, rb);
            run_op(0, ra, rb, 1'($urandom), 0);
        end

        run_op(1, 32'h00003C00, 32'h00004000, 1'b0, 0);
        for (int i = 0; i < 15; i++) begin
            ra = $urandom & 32'h0000FFFF;
            rb = $urandom & 32'h0000FFFF;
            run_op(1, ra, rb, 1'($urandom), 0);
        end

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q0.size() + q1.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Parametrised, multi-cycle IEEE-754-style floating-point add/subtract unit with bit-serial operand load and bit-serial result unload. It is the next generation of the team's fp32 adder sequencer. New behaviour over that sequencer:
- generic exponent and mantissa widths
- add/subtract mode
- automatic operand swap
- round-to-nearest-even
- exact-zero detection
- a re-armable handshake instead of terminal halt states

It sits between the chip's serial I/O pins and nothing else: a self-contained arithmetic core.

## Interface
- EXP_W, 8, exponent width (≥3); bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, sampled at posedge
- start  in  1  request; accepted only in IDLE
- sub  in  1  0 = A+B, 1 = A−B; sampled with accepted start
- sdi  in  1  serial operand bit, MSB first
- sdo  out  1  serial result bit, MSB first; 0 when sdo_valid=0
- sdo_valid  out  1  high for exactly W cycles per operation
- busy  out  1  high from accepted start to done pulse inclusive
- done  out  1  one-cycle pulse after last result bit
- over, under, zero  out  1 each  result flags

## Operation
- Reset: all outputs 0, FSM → IDLE, all registers cleared.
- FSM: IDLE → LOAD_A → LOAD_B → UNPACK → ALIGN → ADD → NORM → ROUND → PACK → SHOUT → IDLE.
- Load: LOAD_A shifts A in at the LSB for W cycles; LOAD_B does the same for B.
- Unpack:
  - B's sign is XORed with sub.
  - A field with exp=0 is treated as zero; its fraction is ignored (flush-to-zero).
  - A field with exp=all-ones on either operand forces the result to ±inf with over=1, taking the sign of the first such operand, and skips to PACK.
- Swap: if |B|>|A| (compare exponent, then fraction), swap the operands so that exponent-A ≥ exponent-B.
- Internal significand: carry + hidden bit + MAN_W + guard/round/sticky = MAN_W+5 bits.
- ALIGN: shifts B right one bit per cycle for min(eA−eB, MAN_W+3) cycles. Every shifted-out 1 is ORed into sticky. The cycle count is 0 when the exponents are equal.
- ADD: effective operation is subtract if the signs differ. Result sign = sign of the larger operand.
- Exact zero: if the sum is exactly 0, result = +0, zero=1, skip to PACK.
- NORM:
  - on carry, shift right 1 bit (sticky-preserving) and exponent+1;
  - otherwise shift left 1 bit per cycle, exponent−1, while the hidden bit is 0.
  - If the exponent would reach 0: result = signed zero, under=1, go to PACK.
- ROUND:
  - increment when G & (R|S|LSB).
  - A carry-out from rounding renormalises: shift right, exponent+1.
- Overflow: exponent reaching all-ones after NORM or ROUND gives ±inf (fraction 0), over=1.
- Flags are mutually exclusive. They are cleared when a start is accepted.

## Timing
- Accept: start=1 in IDLE at edge t is accepted. busy=1 from t+1.
- Operand A: sdi sampled at edges t+1 … t+W (A MSB at t+1).
- Operand B: sdi sampled at edges t+W+1 … t+2W.
- Compute phase (UNPACK→PACK): at most 2·MAN_W+12 cycles, data-dependent.
- Shift-out: sdo_valid=1 for W consecutive cycles, with result MSB in the first cycle.
  - over/under/zero are valid from the first sdo_valid cycle and held until the next accepted start.
- Completion: done=1 for the single cycle after the last sdo_valid cycle; busy falls together with done. The FSM is in IDLE on the following cycle. A start asserted in the done cycle is ignored; start is accepted from the next cycle.
- start while busy is ignored; no queueing.
- sub changes after acceptance have no effect.
- reset asserted in any state: at the next edge all outputs are 0 and the FSM is in IDLE. A partial operand or result is discarded.

## Test plan
- 0x3F800000 + 0x40000000, sub=0 → 0x40400000; flags 0; sdo_valid exactly 32 cycles; done 1 cycle.
- 0x3FC00000 − 0x3FC00000 (sub=1) → 0x00000000, zero=1, under=0. Then 0x40000000 + 0xC0400000 (swap path) → 0xBF800000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, over=1. Then 0x7F800000 + 0x3F800000 → 0x7F800000, over=1.
- RNE:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000;
  - 0x3F800000 + 0x33800001 → 0x3F800001;
  - 0x3F800000 + 0x00800000 (diff saturation) → 0x3F800000.
- Underflow and flush: 0x00800001 − 0x00800000 → 0x00000000, under=1. Then 0x00000005 + 0x3F800000 → 0x3F800000 (denormal flushed).
- Control:
  - start pulsed during LOAD_B and during SHOUT → ignored, result unchanged;
  - reset asserted mid-LOAD_B → IDLE next edge, all outputs 0; a fresh operation then completes correctly;
  - EXP_W=5, MAN_W=10 build: 0x3C00 + 0x4000 → 0x4200.
